rifl_tx_arbiter: RTL

RIFL_TX_ARBITER -- requirements
Module: rifl_tx_arbiter

---
 rtl/rifl_tx_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/rifl_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI4-Stream requesters
// onto one RIFL TX stream. Grant is held from first beat until the tlast handshake.
module rifl_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_up,
    input  logic [NUM_SRC*112-1:0]     s_axis_tdata,
    input  logic [NUM_SRC*14-1:0]      s_axis_tkeep,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic [111:0]               m_axis_tdata,
    output logic [13:0]                m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       grant_active,
    output logic [CNT_WIDTH-1:0]       pkt_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int DW = 112;
    localparam int KW = 14;

    typedef enum logic [1:0] {IDLE, ARB, PASS} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_last;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [GW-1:0]        w_sel;
    logic [GW-1:0]        w_idx;
    logic                 w_any;
    logic                 w_last_hs;

    // Round-robin search starting one past the last packet's owner, with wrap.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        w_any = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = GW'((int'(r_last) + k) % NUM_SRC);
            if (!w_any && s_axis_tvalid[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    // Output mux is purely combinational so reset blanks outputs in the same cycle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (r_state == PASS) begin
            m_axis_tdata           = s_axis_tdata[32'(r_grant)*DW +: DW];
            m_axis_tkeep           = s_axis_tkeep[32'(r_grant)*KW +: KW];
            m_axis_tlast           = s_axis_tlast[r_grant];
            m_axis_tvalid          = s_axis_tvalid[r_grant];
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    assign w_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (tx_up) w_next = ARB;
            ARB: begin
                if (!tx_up)     w_next = IDLE;
                else if (w_any) w_next = PASS;
            end
            // Link drop mid-packet is honoured only after the packet completes.
            PASS:    if (w_last_hs) w_next = tx_up ? ARB : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_SRC - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ARB && tx_up && w_any)
                r_grant <= w_sel;
            if (w_last_hs) begin
                r_last <= r_grant;
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign grant_id     = r_grant;
    assign grant_active = (r_state == PASS);
    assign pkt_cnt      = r_cnt;

endmodule
